// File: rtl/fmac_stream.sv
// fmac_stream: pipelined single-precision multiply-accumulate over framed vectors.
// Operand regs (S1) -> product reg (S2) -> accumulator (S3) -> held output reg.
// Build option: define FMAC_SAT_EN to clamp overflowed values to max finite
// instead of infinity; the sticky out_ovf flag is the same in both builds.
module fmac_stream #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [31:0]      In1,
    input  logic [31:0]      In2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      MacOut,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

`ifdef FMAC_SAT_EN
    localparam logic [30:0] OVF_MAG = 31'h7F7FFFFF;
`else
    localparam logic [30:0] OVF_MAG = 31'h7F800000;
`endif

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept, load_out;
    logic [2:0]        vld_pipe, lst_pipe;   // [0]=S1, [1]=S2, [2]=S3
    logic [31:0]       s1_a, s1_b;
    logic [31:0]       s2_p;
    logic              s2_zero, s2_ovf;
    logic [31:0]       acc;
    logic              acc_sat, acc_ovf;
    logic [CNT_W-1:0]  cnt;

    assign accept   = in_valid & in_ready;
    // The accumulator holds the finished sum once the last element has left S3.
    assign load_out = vld_pipe[2] & lst_pipe[2];

    // State register
    always_ff @(posedge CLK) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and handshake outputs; in_ready is 1 in IDLE/ACC, so in_valid alone means accept there
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACC: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_last ? DRAIN : ACC;
            end
            DRAIN: if (load_out) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // S1 operand capture and valid/last shift registers
    always_ff @(posedge CLK) begin
        if (!rst) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], accept};
            lst_pipe <= {lst_pipe[1:0], accept & in_last};
            if (accept) begin
                s1_a <= In1;
                s1_b <= In2;
            end
        end
    end

    // Multiplier: exponents kept biased-plus-127 in 10 bits so no signed math is needed
    logic [47:0] mprod;
    logic        m_norm, m_sgn, m_ovf, m_zero;
    logic [9:0]  m_eraw, m_eadj;
    logic [22:0] m_mant;
    logic [31:0] m_res;
    always_comb begin
        mprod  = {24'b0, 1'b1, s1_a[22:0]} * {24'b0, 1'b1, s1_b[22:0]};
        m_norm = mprod[47];
        m_sgn  = s1_a[31] ^ s1_b[31];
        m_eraw = {2'b0, s1_a[30:23]} + {2'b0, s1_b[30:23]} + {9'b0, m_norm};
        m_eadj = m_eraw - 10'd127;
        m_mant = m_norm ? mprod[46:24] : mprod[45:23];
        m_ovf  = (s1_a[30:23] == 8'hFF) || (s1_b[30:23] == 8'hFF) || (m_eraw >= 10'd382);
        m_zero = !m_ovf && ((s1_a[30:23] == 8'h00) || (s1_b[30:23] == 8'h00) || (m_eraw <= 10'd127));
        if (m_ovf)       m_res = {m_sgn, OVF_MAG};
        else if (m_zero) m_res = 32'h0;
        else             m_res = {m_sgn, m_eadj[7:0], m_mant};
    end

    // S2 product register
    always_ff @(posedge CLK) begin
        if (!rst) begin
            s2_p    <= '0;
            s2_zero <= 1'b0;
            s2_ovf  <= 1'b0;
        end else if (vld_pipe[0]) begin
            s2_p    <= m_res;
            s2_zero <= m_zero;
            s2_ovf  <= m_ovf;
        end
    end

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        lzc24 = 5'd0;
        for (int i = 0; i < 24; i++)
            if (v[i]) lzc24 = 5'(23 - i);
    endfunction

    // Adder for two nonzero finite terms: align the smaller magnitude by truncating shift
    logic [31:0] big, sml;
    logic [7:0]  a_d;
    logic [23:0] a_mb, a_ms, a_diff, a_shl;
    logic [24:0] a_sum;
    logic [4:0]  a_lz;
    logic [31:0] add_res;
    logic        add_ovf;
    always_comb begin
        add_ovf = 1'b0;
        if (acc[30:0] >= s2_p[30:0]) begin
            big = acc;  sml = s2_p;
        end else begin
            big = s2_p; sml = acc;
        end
        a_d    = big[30:23] - sml[30:23];
        a_mb   = {1'b1, big[22:0]};
        a_ms   = (a_d >= 8'd24) ? 24'h0 : ({1'b1, sml[22:0]} >> a_d);
        a_sum  = {1'b0, a_mb} + {1'b0, a_ms};
        a_diff = a_mb - a_ms;
        a_lz   = lzc24(a_diff);
        a_shl  = a_diff << a_lz;
        if (big[31] == sml[31]) begin
            if (a_sum[24]) begin
                if (big[30:23] == 8'hFE) begin
                    add_ovf = 1'b1;
                    add_res = {big[31], OVF_MAG};
                end else begin
                    add_res = {big[31], big[30:23] + 8'd1, a_sum[23:1]};
                end
            end else begin
                add_res = {big[31], big[30:23], a_sum[22:0]};
            end
        end else if (a_diff == 24'h0 || big[30:23] <= {3'b0, a_lz}) begin
            add_res = 32'h0;   // exact cancellation or underflow
        end else begin
            add_res = {big[31], big[30:23] - {3'b0, a_lz}, a_shl[22:0]};
        end
    end

    // S3 accumulator with sticky overflow; cleared as the result moves to the output register
    always_ff @(posedge CLK) begin
        if (!rst || load_out) begin
            acc     <= '0;
            acc_sat <= 1'b0;
            acc_ovf <= 1'b0;
        end else if (vld_pipe[1]) begin
            if (acc_sat) begin
                acc <= acc;
            end else if (s2_ovf) begin
                acc     <= s2_p;
                acc_sat <= 1'b1;
                acc_ovf <= 1'b1;
            end else if (s2_zero) begin
                acc <= acc;
            end else if (acc[30:23] == 8'h00) begin
                acc <= s2_p;
            end else begin
                acc     <= add_res;
                acc_sat <= add_ovf;
                acc_ovf <= acc_ovf | add_ovf;
            end
        end
    end

    // Element counter, saturating
    always_ff @(posedge CLK) begin
        if (!rst || load_out)          cnt <= '0;
        else if (accept && cnt != '1) cnt <= cnt + 1'b1;
    end

    // Output register, held while out_valid is high
    always_ff @(posedge CLK) begin
        if (!rst) begin
            MacOut    <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (load_out) begin
            MacOut    <= acc;
            out_count <= cnt;
            out_ovf   <= acc_ovf;
        end
    end

endmodule
